// File: rtl/object_mover.sv
// Moves an (x, y) sprite position inside an inclusive box: manual steering or autonomous bounce.
// Latency: Direction is registered (1 cycle) before use; position/Edge update on the edge where Tick=1.
// Backpressure: none; free-running, Recenter/Reset restart the tick interval.
//
// Ports:
//   Clock, Reset (sync, active-high), Direction[3:0] = {Right, Left, Down, Up} held buttons,
//   Mode (0 manual, 1 bounce), Recenter (return to INIT position),
//   x_pos/y_pos registered position, Edge[3:0] = {Right, Left, Bottom, Top} one-cycle contact pulses,
//   Tick high during the cycle whose rising edge applies a movement step.
module object_mover #(
    parameter int unsigned W        = 10,
    parameter int unsigned X_MIN    = 146,
    parameter int unsigned X_MAX    = 781,
    parameter int unsigned Y_MIN    = 37,
    parameter int unsigned Y_MAX    = 513,
    parameter int unsigned X_INIT   = 400,
    parameter int unsigned Y_INIT   = 262,
    parameter int unsigned STEP     = 1,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [3:0]   Direction,
    input  logic         Mode,
    input  logic         Recenter,
    output logic [W-1:0] x_pos,
    output logic [W-1:0] y_pos,
    output logic [3:0]   Edge,
    output logic         Tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    // W+1-bit copies so bound comparisons never wrap.
    localparam logic [W:0] X_MIN_E = (W+1)'(X_MIN);
    localparam logic [W:0] X_MAX_E = (W+1)'(X_MAX);
    localparam logic [W:0] Y_MIN_E = (W+1)'(Y_MIN);
    localparam logic [W:0] Y_MAX_E = (W+1)'(Y_MAX);
    localparam logic [W:0] STEP_E  = (W+1)'(STEP);

    localparam logic [W-1:0] X_MIN_V  = W'(X_MIN);
    localparam logic [W-1:0] X_MAX_V  = W'(X_MAX);
    localparam logic [W-1:0] Y_MIN_V  = W'(Y_MIN);
    localparam logic [W-1:0] Y_MAX_V  = W'(Y_MAX);
    localparam logic [W-1:0] X_INIT_V = W'(X_INIT);
    localparam logic [W-1:0] Y_INIT_V = W'(Y_INIT);
    localparam logic [W-1:0] STEP_V   = W'(STEP);

    logic [W-1:0]  x_q, x_d, y_q, y_d;
    logic          vx_q, vx_d, vy_q, vy_d;      // 1 = moving right / down
    logic [3:0]    dir_q, dir_d;
    logic [3:0]    edge_q, edge_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic go_up, go_dn, go_lt, go_rt;
    logic [W:0] x_ext, y_ext;

    assign Tick  = (cnt_q == CNT_LAST);
    assign x_ext = {1'b0, x_q};
    assign y_ext = {1'b0, y_q};

    // Opposing buttons cancel; bounce mode follows the velocity bits instead.
    assign go_up = Mode ? ~vy_q : (dir_q[0] & ~dir_q[1]);
    assign go_dn = Mode ?  vy_q : (dir_q[1] & ~dir_q[0]);
    assign go_lt = Mode ? ~vx_q : (dir_q[2] & ~dir_q[3]);
    assign go_rt = Mode ?  vx_q : (dir_q[3] & ~dir_q[2]);

    // A step whose result lies on a bound (exact landing or clamp) counts as a
    // contact: the Edge bit pulses and, in bounce mode, that axis reflects.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        vx_d   = vx_q;
        vy_d   = vy_q;
        cnt_d  = cnt_q;
        dir_d  = Direction;
        edge_d = '0;
        if (Recenter) begin
            x_d   = X_INIT_V;
            y_d   = Y_INIT_V;
            vx_d  = 1'b1;
            vy_d  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = Tick ? '0 : cnt_q + 1'b1;
            if (Tick) begin
                if (go_up) begin
                    if (y_ext <= Y_MIN_E + STEP_E) begin
                        y_d       = Y_MIN_V;
                        edge_d[0] = 1'b1;
                        if (Mode) vy_d = 1'b1;
                    end else begin
                        y_d = y_q - STEP_V;
                    end
                end else if (go_dn) begin
                    if (y_ext + STEP_E >= Y_MAX_E) begin
                        y_d       = Y_MAX_V;
                        edge_d[1] = 1'b1;
                        if (Mode) vy_d = 1'b0;
                    end else begin
                        y_d = y_q + STEP_V;
                    end
                end
                if (go_lt) begin
                    if (x_ext <= X_MIN_E + STEP_E) begin
                        x_d       = X_MIN_V;
                        edge_d[2] = 1'b1;
                        if (Mode) vx_d = 1'b1;
                    end else begin
                        x_d = x_q - STEP_V;
                    end
                end else if (go_rt) begin
                    if (x_ext + STEP_E >= X_MAX_E) begin
                        x_d       = X_MAX_V;
                        edge_d[3] = 1'b1;
                        if (Mode) vx_d = 1'b0;
                    end else begin
                        x_d = x_q + STEP_V;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            x_q    <= X_INIT_V;
            y_q    <= Y_INIT_V;
            vx_q   <= 1'b1;
            vy_q   <= 1'b1;
            dir_q  <= '0;
            edge_q <= '0;
            cnt_q  <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            vx_q   <= vx_d;
            vy_q   <= vy_d;
            dir_q  <= dir_d;
            edge_q <= edge_d;
            cnt_q  <= cnt_d;
        end
    end

    assign x_pos = x_q;
    assign y_pos = y_q;
    assign Edge  = edge_q;

endmodule

// File: tb/tb_object_mover.sv
// Bench for object_mover: two instances (STEP=3/TICK_DIV=4 and STEP=1/TICK_DIV=1)
// checked every cycle against a behavioural model, plus vector table and corner sequences.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_object_mover;
    localparam int W = 10;

    logic       Clock = 1'b0;
    logic       rst;
    logic [3:0] dir_s  [2];
    logic       mode_s [2];
    logic       rc_s   [2];
    logic [W-1:0] xo [2];
    logic [W-1:0] yo [2];
    logic [3:0]   eo [2];
    logic         to [2];

    int stp [2] = '{3, 1};
    int tdv [2] = '{4, 1};

    // Model state: position, velocity sign (+1/-1), tick phase, sampled buttons, edge pulse.
    int         mx [2], my [2], mvx [2], mvy [2], mcnt [2];
    logic [3:0] mdir [2], medge [2];

    int n_vec = 0;
    int n_bad = 0;

    object_mover #(.STEP(3), .TICK_DIV(4)) dut_a (
        .Clock(Clock), .Reset(rst), .Direction(dir_s[0]), .Mode(mode_s[0]),
        .Recenter(rc_s[0]), .x_pos(xo[0]), .y_pos(yo[0]), .Edge(eo[0]), .Tick(to[0])
    );

    object_mover #(.STEP(1), .TICK_DIV(1)) dut_b (
        .Clock(Clock), .Reset(rst), .Direction(dir_s[1]), .Mode(mode_s[1]),
        .Recenter(rc_s[1]), .x_pos(xo[1]), .y_pos(yo[1]), .Edge(eo[1]), .Tick(to[1])
    );

    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // One axis step of signed size d, landing on or beyond a bound stops there.
    function automatic void axis(input int p, input int lo, input int hi, input int d,
                                 output int np, output logic hl, output logic hh);
        int t;
        np = p; hl = 1'b0; hh = 1'b0;
        t  = p + d;
        if (d < 0) begin
            if (t <= lo) begin np = lo; hl = 1'b1; end else np = t;
        end else if (d > 0) begin
            if (t >= hi) begin np = hi; hh = 1'b1; end else np = t;
        end
    endfunction

    task automatic model_update(input int k);
        logic hl, hh, vl, vh, tick;
        int dx, dy, nx, ny;
        tick = (mcnt[k] == tdv[k] - 1);
        if (rst) begin
            mx[k] = 400; my[k] = 262; mvx[k] = 1; mvy[k] = 1;
            mcnt[k] = 0; mdir[k] = 4'b0; medge[k] = 4'b0;
        end else if (rc_s[k]) begin
            mx[k] = 400; my[k] = 262; mvx[k] = 1; mvy[k] = 1;
            mcnt[k] = 0; mdir[k] = dir_s[k]; medge[k] = 4'b0;
        end else begin
            medge[k] = 4'b0;
            if (tick) begin
                if (mode_s[k]) begin
                    dx = mvx[k] * stp[k];
                    dy = mvy[k] * stp[k];
                end else begin
                    dx = (mdir[k][3] && !mdir[k][2]) ? stp[k] : ((mdir[k][2] && !mdir[k][3]) ? -stp[k] : 0);
                    dy = (mdir[k][1] && !mdir[k][0]) ? stp[k] : ((mdir[k][0] && !mdir[k][1]) ? -stp[k] : 0);
                end
                axis(mx[k], 146, 781, dx, nx, hl, hh);
                axis(my[k], 37, 513, dy, ny, vl, vh);
                mx[k] = nx;
                my[k] = ny;
                medge[k] = {hh, hl, vh, vl};
                if (mode_s[k]) begin
                    if (hl || hh) mvx[k] = -mvx[k];
                    if (vl || vh) mvy[k] = -mvy[k];
                end
            end
            mcnt[k] = (mcnt[k] + 1) % tdv[k];
            mdir[k] = dir_s[k];
        end
    endtask

    task automatic check_model(input int k);
        chk($sformatf("model.x[%0d]", k), 32'(xo[k]), 32'(mx[k]));
        chk($sformatf("model.y[%0d]", k), 32'(yo[k]), 32'(my[k]));
        chk($sformatf("model.edge[%0d]", k), 32'(eo[k]), 32'(medge[k]));
        chk($sformatf("model.tick[%0d]", k), 32'(to[k]), 32'(mcnt[k] == tdv[k] - 1));
    endtask

    task automatic step();
        @(posedge Clock);
        for (int k = 0; k < 2; k++) model_update(k);
        @(negedge Clock);
        for (int k = 0; k < 2; k++) check_model(k);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_pos(input string nm, input int k, input int ex, input int ey, input logic [3:0] ee);
        chk({nm, ".x"}, 32'(xo[k]), ex);
        chk({nm, ".y"}, 32'(yo[k]), ey);
        chk({nm, ".edge"}, 32'(eo[k]), 32'(ee));
    endtask

    typedef struct {
        logic [3:0] dir;
        logic       mode;
        int         n;
        int         ex;
        int         ey;
        logic [3:0] ee;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // Instance A (STEP=3, TICK_DIV=4); every segment is a whole number of tick intervals.
        tbl[0] = '{4'b0000, 1'b0,   8, 400, 262, 4'b0000};
        tbl[1] = '{4'b1000, 1'b0,  40, 430, 262, 4'b0000};
        tbl[2] = '{4'b0011, 1'b0,   8, 430, 262, 4'b0000};
        tbl[3] = '{4'b0001, 1'b0,   4, 430, 259, 4'b0000};
        tbl[4] = '{4'b1110, 1'b0,   4, 430, 262, 4'b0000};
        tbl[5] = '{4'b0100, 1'b0, 376, 148, 262, 4'b0000};
        tbl[6] = '{4'b0100, 1'b0,   4, 146, 262, 4'b0100};
        tbl[7] = '{4'b0100, 1'b0,   4, 146, 262, 4'b0100};
        tbl[8] = '{4'b0000, 1'b0,   4, 146, 262, 4'b0000};
        tbl[9] = '{4'b0000, 1'b1,   4, 149, 265, 4'b0000};

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            dir_s[k] = 4'b0; mode_s[k] = 1'b0; rc_s[k] = 1'b0;
        end
        run(2);
        chk_pos("reset.a", 0, 400, 262, 4'b0000);
        chk("reset.tick_a", 32'(to[0]), 32'd0);
        chk("reset.tick_b", 32'(to[1]), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            dir_s[0]  = tbl[i].dir;
            mode_s[0] = tbl[i].mode;
            run(tbl[i].n);
            chk_pos($sformatf("tbl[%0d]", i), 0, tbl[i].ex, tbl[i].ey, tbl[i].ee);
        end

        // Recenter on A mid-interval restarts the tick count.
        run(2);
        rc_s[0] = 1'b1;
        step();
        rc_s[0] = 1'b0;
        chk_pos("a.recenter", 0, 400, 262, 4'b0000);
        chk("a.recenter.tick", 32'(to[0]), 32'd0);
        run(3);
        chk("a.restart.tick", 32'(to[0]), 32'd1);
        chk("a.restart.x", 32'(xo[0]), 32'd400);
        step();
        chk_pos("a.restart.move", 0, 403, 265, 4'b0000);

        // B: Recenter wins over a tick with Right held.
        dir_s[1] = 4'b1000;
        step();
        rc_s[1] = 1'b1;
        step();
        rc_s[1] = 1'b0;
        chk_pos("b.recenter", 1, 400, 262, 4'b0000);

        // B: position at (780, 512) then bounce into the corner.
        run(379);
        dir_s[1] = 4'b0010;
        run(251);
        chk_pos("b.pre_corner", 1, 780, 512, 4'b0000);
        dir_s[1]  = 4'b0000;
        mode_s[1] = 1'b1;
        step();
        chk_pos("b.corner", 1, 781, 513, 4'b1010);
        step();
        chk_pos("b.corner_reflect", 1, 780, 512, 4'b0000);

        // B: right wall alone, y keeps going.
        mode_s[1] = 1'b0;
        dir_s[1]  = 4'b1000;
        rc_s[1]   = 1'b1;
        step();
        rc_s[1] = 1'b0;
        run(379);
        dir_s[1] = 4'b0000;
        step();
        chk_pos("b.at780", 1, 780, 262, 4'b0000);
        mode_s[1] = 1'b1;
        step();
        chk_pos("b.wall", 1, 781, 263, 4'b1000);
        step();
        chk_pos("b.reflect1", 1, 780, 264, 4'b0000);
        step();
        chk_pos("b.reflect2", 1, 779, 265, 4'b0000);

        // Reset mid-bounce restores INIT position and positive velocity.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_pos("b.reset", 1, 400, 262, 4'b0000);
        chk("a.reset.tick", 32'(to[0]), 32'd0);
        run(3);
        chk_pos("b.after_reset", 1, 403, 265, 4'b0000);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < 2; k++) begin
                dir_s[k] = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 15) == 0) mode_s[k] = ~mode_s[k];
                rc_s[k] = ($urandom_range(0, 63) == 0);
            end
            rst = ($urandom_range(0, 255) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
